// File: rtl/bcd_countdown_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding and BCD digit constants.
package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Invalid BCD digits (A..F) saturate to 9 so the count is always valid BCD.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One down-counting decade cell: synchronous load, decrement with 0 -> 9 wrap and borrow out.
module bcd_down_digit
  import bcd_countdown_pkg::*;
(
  input  logic       clk,
  input  logic       notMr,
  input  logic       load,
  input  logic [3:0] dIn,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       bo
);

  always_ff @(posedge clk or negedge notMr) begin
    if (!notMr) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= dIn;
    end else if (dec) begin
      digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign bo = dec & (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer with load, start, pause via en, and stop or auto-reload at expiry.
module bcd_countdown
  import bcd_countdown_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  notMr,
  input  logic                  notLoad,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  en,
  input  logic                  start,
  input  logic                  autoReload,
  output logic [4*DIGITS-1:0]   q,
  output logic                  running,
  output logic                  done
);

  localparam int unsigned W = 4 * DIGITS;

  state_t         state;
  state_t         next_state;
  logic [W-1:0]   reload_q;
  logic [W-1:0]   d_clamped;
  logic [W-1:0]   load_val;
  logic           load_en;
  logic           dec0;
  logic           done_n;
  logic           q_zero;
  logic           q_one;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] bo;
  logic           unused_msd_bo;

  assign q_zero        = (q == '0);
  assign q_one         = (q == W'(1));
  assign unused_msd_bo = bo[DIGITS-1];

  // Expiry and restart reuse the digits' load path instead of a separate clear.
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    load_val   = d_clamped;
    dec0       = 1'b0;
    done_n     = 1'b0;
    if (!notLoad) begin
      load_en    = 1'b1;
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !q_zero) next_state = RUN;
        end
        RUN: begin
          if (en && q_one) begin
            done_n  = 1'b1;
            load_en = 1'b1;
            if (autoReload) begin
              load_val = reload_q;
            end else begin
              load_val   = '0;
              next_state = EXPIRED;
            end
          end else if (en && !q_zero) begin
            dec0 = 1'b1;
          end
        end
        EXPIRED: begin
          if (start && (reload_q != '0)) begin
            load_en    = 1'b1;
            load_val   = reload_q;
            next_state = RUN;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge notMr) begin
    if (!notMr) begin
      state    <= IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      reload_q <= '0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      done    <= done_n;
      if (!notLoad) reload_q <= d_clamped;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign d_clamped[4*i +: 4] = bcd_clamp(d[4*i +: 4]);

    if (i == 0) begin : g_lsd
      assign dec[i] = dec0;
    end else begin : g_chain
      assign dec[i] = dec[i-1] & bo[i-1];
    end

    bcd_down_digit u_digit (
      .clk   (clk),
      .notMr (notMr),
      .load  (load_en),
      .dIn   (load_val[4*i +: 4]),
      .dec   (dec[i]),
      .digit (q[4*i +: 4]),
      .bo    (bo[i])
    );
  end

endmodule
